// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between instruction fetch (F) and load/store data (D).
// D normally has priority. A streak counter tracks consecutive D grants made
// while F was waiting, and forces an F grant once the streak reaches
// MAX_D_STREAK, so fetch always makes progress. Only one access is in flight
// at a time, and every output is registered.
//
// Access sequence (edge 0 = the IDLE edge that samples the requests):
//   IDLE   -> SETUP  : winner chosen, address/we/wdata latched into mem* regs
//   SETUP  -> ACCESS : memEn rises at edge 1
//   ACCESS -> DONE   : on memReady, or on timeout when ARB_TIMEOUT_EN is defined
//   DONE   -> IDLE   : the winner's ack is high for exactly this one cycle
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   : ACCESS gives up after TIMEOUT_CYC cycles without memReady.
//               The winner is acked with zero read data, and the sticky
//               timeoutErr flag is set until reset.
//   Undefined : ACCESS waits indefinitely and timeoutErr is tied low.
//
// Ports
//   clk, rstN                   clock and synchronous active-low reset
//   fReq/fAddr                  fetch request (held until fAck) and its address
//   fRdata/fAck                 fetch read data and one-cycle completion pulse
//   dReq/dWe/dAddr/dWdata       data request: 1 = store, 0 = load
//   dRdata/dAck                 load data and one-cycle completion pulse
//   memEn/memWe/memAddr/memWdata  memory-side access strobe and payload
//   memRdata/memReady           memory read data and completion strobe
//   grantId                     owner of the current access: 0 = F, 1 = D
//   busy                        high whenever the FSM is not IDLE
//   timeoutErr                  sticky timeout flag
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned AW           = 16,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          fReq,
    input  logic [AW-1:0] fAddr,
    output logic [DW-1:0] fRdata,
    output logic          fAck,
    input  logic          dReq,
    input  logic          dWe,
    input  logic [AW-1:0] dAddr,
    input  logic [DW-1:0] dWdata,
    output logic [DW-1:0] dRdata,
    output logic          dAck,
    output logic          memEn,
    output logic          memWe,
    output logic [AW-1:0] memAddr,
    output logic [DW-1:0] memWdata,
    input  logic [DW-1:0] memRdata,
    input  logic          memReady,
    output logic          grantId,
    output logic          busy,
    output logic          timeoutErr
);

    // Reject out-of-range configurations at elaboration time.
    if (MAX_D_STREAK > 15) begin : g_bad_max_d_streak
        $error("mem_port_arbiter: MAX_D_STREAK must be in 0..15");
    end
    if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 255)) begin : g_bad_timeout_cyc
        $error("mem_port_arbiter: TIMEOUT_CYC must be in 1..255");
    end

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [3:0] STREAK_SAT = 4'hF;
    localparam logic       FORCE_EN   = (MAX_D_STREAK != 0);

    logic [1:0]    state_q,     state_d;
    logic [3:0]    streak_q,    streak_d;
    logic          grant_q,     grant_d;
    logic          mem_en_q,    mem_en_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] f_rdata_q,   f_rdata_d;
    logic [DW-1:0] d_rdata_q,   d_rdata_d;
    logic          f_ack_q,     f_ack_d;
    logic          d_ack_q,     d_ack_d;
    logic          busy_q,      busy_d;
    logic          pick_f;

`ifdef ARB_TIMEOUT_EN
    // Last value of the ACCESS cycle counter before the access is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] to_cnt_q, to_cnt_d;
    logic       to_err_q, to_err_d;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement leaves one unassigned (no inferred latch).
        state_d     = state_q;
        streak_d    = streak_q;
        grant_d     = grant_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        f_rdata_d   = f_rdata_q;
        d_rdata_d   = d_rdata_q;
        f_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        pick_f      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        to_err_d    = to_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (fReq || dReq) begin
                    // D wins a tie unless F has waited through MAX_D_STREAK D grants.
                    pick_f  = fReq && (!dReq || (FORCE_EN && (streak_q == STREAK_MAX)));
                    state_d = ST_SETUP;
                    grant_d = !pick_f;
                    if (pick_f) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = fAddr;
                        mem_wdata_d = '0;
                        streak_d    = '0;
                    end else begin
                        mem_we_d    = dWe;
                        mem_addr_d  = dAddr;
                        mem_wdata_d = dWdata;
                        // The streak only grows while F is actually being held off.
                        if (fReq && (streak_q != STREAK_SAT)) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end
                end
            end

            ST_SETUP: begin
                state_d  = ST_ACCESS;
                mem_en_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end

            ST_ACCESS: begin
                if (memReady) begin
                    state_d  = ST_DONE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    f_ack_d  = !grant_q;
                    d_ack_d  = grant_q;
                    // A store leaves the load-data register untouched.
                    if (!grant_q) begin
                        f_rdata_d = memRdata;
                    end else if (!mem_we_q) begin
                        d_rdata_d = memRdata;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    // Abandon the access: ack the winner with zero data and flag it.
                    state_d  = ST_DONE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    f_ack_d  = !grant_q;
                    d_ack_d  = grant_q;
                    to_err_d = 1'b1;
                    if (!grant_q) begin
                        f_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
`endif
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q     <= ST_IDLE;
            streak_q    <= '0;
            grant_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            grant_q     <= grant_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            f_rdata_q   <= f_rdata_d;
            d_rdata_q   <= d_rdata_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rstN) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign timeoutErr = to_err_q;
`else
    assign timeoutErr = 1'b0;
`endif

    assign fRdata   = f_rdata_q;
    assign fAck     = f_ack_q;
    assign dRdata   = d_rdata_q;
    assign dAck     = d_ack_q;
    assign memEn    = mem_en_q;
    assign memWe    = mem_we_q;
    assign memAddr  = mem_addr_q;
    assign memWdata = mem_wdata_q;
    assign grantId  = grant_q;
    assign busy     = busy_q;

endmodule
